wb_skid_reg: RTL and testbench
==============================

# wb_skid_reg

Parametrised MEM→WB pipeline register with valid/ready handshake, a one-entry skid buffer, synchronous flush and a writeback forwarding port. It sits between the data-memory stage and the register-file write port. It replaces the fixed-width, always-advancing MEM/WB latch, so that a writeback-side stall does not lose in-flight instructions. It also resolves the MemToReg select inside the stage.

## Interface
Parameters:
- DATA_W, 32, width of memory read data, ALU result and write data
- REG_ADDR_W, 5, register-file address width
- WB_CTRL_W, 2, WB control width; bit [1] = RegWrite, bit [0] = MemToReg, extra bits passed through

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  synchronous, active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream offers an instruction
- in_ready  out  1  stage can accept this cycle
- in_wb_ctrl  in  WB_CTRL_W  WB control bits
- in_mem_data  in  DATA_W  data-memory read data
- in_alu_result  in  DATA_W  ALU result
- in_write_reg  in  REG_ADDR_W  destination register
- out_valid  out  1  head entry present
- out_ready  in  1  register file / WB consumer accepts
- out_reg_write  out  1  RegWrite, qualified (see Operation)
- out_wb_ctrl  out  WB_CTRL_W  raw control bits of head entry
- out_write_data  out  DATA_W  MemToReg ? mem_data : alu_result, of head entry
- out_write_reg  out  REG_ADDR_W  destination of head entry
- fwd_valid  out  1  head entry will write a nonzero register
- fwd_reg  out  REG_ADDR_W  equals out_write_reg
- fwd_data  out  DATA_W  equals out_write_data

## Operation
Storage:
- Two entries, main (head) and skid.
- Each entry holds {valid, wb_ctrl, write_data, write_reg}.
- write_data is selected at capture time, so only one DATA_W word is stored per entry.

States, from the occupancy:
- EMPTY: no valid entries.
- ONE: main valid, skid empty.
- FULL: both valid.

Transfers:
- Accept = in_valid && in_ready.
- Drain = out_valid && out_ready.
- in_ready = !skid.valid. It is a registered value with no combinational path from out_ready.

Transitions:
- EMPTY + accept → ONE. The input is written to main.
- ONE + accept, no drain → FULL. The input is written to skid.
- ONE + drain, no accept → EMPTY.
- ONE + accept + drain → ONE. The input replaces main.
- FULL + drain → ONE. Skid moves to main and skid is cleared. Accept is impossible in FULL.
- FULL, no drain → FULL. Hold.

Output qualification:
- out_reg_write = main.valid && main.wb_ctrl[1] && (main.write_reg != 0). Writes to register 0 are suppressed.
- fwd_valid = out_reg_write.

Flush:
- flush=1 clears both valid bits. That same cycle's accept is discarded.
- Data fields need not clear.

Reset:
- reset_n=0 at a clock edge clears all state. It has priority over flush and handshakes.
- Reset values: out_valid=0, in_ready=1, out_reg_write=0, fwd_valid=0, out_wb_ctrl=0, out_write_data=0, out_write_reg=0, fwd_reg=0, fwd_data=0. Data registers are also zeroed on reset.

## Timing
- Latency: an entry accepted at edge N is visible on out_* after edge N. It can drain at edge N+1.
- Throughput: with out_ready held at 1, one instruction is accepted and one drained every cycle, with no bubbles.
- Stall: out_ready=0 absorbs exactly one more instruction. in_ready falls the cycle after the state becomes FULL.
- Release: in_ready rises on the edge where FULL drains.
- Ordering: strict FIFO. The skid entry never overtakes main.
- Held outputs: out_* stay stable while out_valid && !out_ready.
- All outputs are registered or a function of registered state only. No input-to-output combinational path.
- Reset mid-stall: both held entries are dropped and no write is issued.

## Structure
- Package wb_pkg holds WB_REGWRITE_BIT=1 and WB_MEMTOREG_BIT=0, plus the occupancy enum {EMPTY, ONE, FULL}. Future stage registers (ID/EX, EX/MEM) reuse the same package.
- Sub-module wb_entry_reg is the natural split: one entry register with a load enable and a sync clear, instantiated twice.
- The top level holds the occupancy FSM, the MemToReg mux and the qualification logic.

## Test plan
- Streaming, out_ready=1: 4 back-to-back inputs (alu 0x10, 0x20, 0x30, 0x40; ctrl=2'b10; regs 1–4). Required: the same sequence out one cycle later, with out_reg_write=1 each cycle.
- MemToReg: ctrl=2'b11, mem_data=0xDEADBEEF, alu=0x1. Required: out_write_data=0xDEADBEEF. Then ctrl=2'b10 gives 0x1.
- Stall/skid: out_ready=0 for 3 cycles while in_valid=1 (A, B, C). Required: A held; B captured in skid; in_ready=0 from the next cycle; C not accepted. After release, A then B then C drain in order.
- Register 0: ctrl=2'b10, write_reg=0. Required: out_valid=1, out_reg_write=0, fwd_valid=0.
- Flush in FULL, concurrent with in_valid=1: required next cycle out_valid=0, in_ready=1, and the new input is dropped.
- reset_n=0 for 1 cycle mid-stream: required all outputs at their reset values the next cycle, and normal streaming resumes afterwards.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared writeback-control bit positions and stage-register occupancy encoding
package wb_pkg;
  localparam int WB_REGWRITE_BIT = 1;
  localparam int WB_MEMTOREG_BIT = 0;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;
endpackage

// File: rtl/wb_entry_reg.sv
// wb_entry_reg: one pipeline entry {valid, wb_ctrl, write_data, write_reg} with load and sync clear
module wb_entry_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int WB_CTRL_W  = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_clr,
  input  logic                  i_load,
  input  logic                  i_valid,
  input  logic [WB_CTRL_W-1:0]  i_wb_ctrl,
  input  logic [DATA_W-1:0]     i_data,
  input  logic [REG_ADDR_W-1:0] i_reg,
  output logic                  o_valid,
  output logic [WB_CTRL_W-1:0]  o_wb_ctrl,
  output logic [DATA_W-1:0]     o_data,
  output logic [REG_ADDR_W-1:0] o_reg
);
  // clear drops only the valid bit; payload is don't-care once invalid
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      o_valid   <= 1'b0;
      o_wb_ctrl <= '0;
      o_data    <= '0;
      o_reg     <= '0;
    end else if (i_clr) begin
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_valid   <= i_valid;
      o_wb_ctrl <= i_wb_ctrl;
      o_data    <= i_data;
      o_reg     <= i_reg;
    end
  end
endmodule

// File: rtl/wb_skid_reg.sv
// wb_skid_reg: MEM/WB stage register with valid/ready handshake, one-entry skid buffer,
// flush, MemToReg resolution and a writeback forwarding port
module wb_skid_reg import wb_pkg::*; #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int WB_CTRL_W  = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WB_CTRL_W-1:0]  in_wb_ctrl,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [REG_ADDR_W-1:0] in_write_reg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_reg_write,
  output logic [WB_CTRL_W-1:0]  out_wb_ctrl,
  output logic [DATA_W-1:0]     out_write_data,
  output logic [REG_ADDR_W-1:0] out_write_reg,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_reg,
  output logic [DATA_W-1:0]     fwd_data
);
  occ_e                  r_state;
  logic                  w_main_valid, w_skid_valid;
  logic [WB_CTRL_W-1:0]  w_main_ctrl, w_skid_ctrl, w_main_ctrl_in;
  logic [DATA_W-1:0]     w_main_data, w_skid_data, w_main_data_in, w_in_data;
  logic [REG_ADDR_W-1:0] w_main_reg, w_skid_reg, w_main_reg_in;
  logic                  w_accept, w_drain, w_main_ld, w_skid_ld, w_from_skid;
  assign w_in_data   = in_wb_ctrl[WB_MEMTOREG_BIT] ? in_mem_data : in_alu_result;
  assign in_ready    = !w_skid_valid;
  assign w_accept    = in_valid && in_ready;
  assign w_drain     = w_main_valid && out_ready;
  assign w_from_skid = r_state == FULL;
  // main reloads on every drain: from skid when FULL, otherwise from the input (invalid if none)
  assign w_main_ld      = w_drain || (r_state == EMPTY && w_accept);
  assign w_skid_ld      = (r_state == ONE && w_accept && !w_drain) || (r_state == FULL && w_drain);
  assign w_main_ctrl_in = w_from_skid ? w_skid_ctrl : in_wb_ctrl;
  assign w_main_data_in = w_from_skid ? w_skid_data : w_in_data;
  assign w_main_reg_in  = w_from_skid ? w_skid_reg : in_write_reg;
  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      r_state <= EMPTY;
    end else begin
      unique case (r_state)
        EMPTY:   r_state <= w_accept ? ONE : EMPTY;
        ONE:     r_state <= (w_accept && !w_drain) ? FULL : (w_drain && !w_accept) ? EMPTY : ONE;
        FULL:    r_state <= w_drain ? ONE : FULL;
        default: r_state <= EMPTY;
      endcase
    end
  end
  wb_entry_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .WB_CTRL_W(WB_CTRL_W)) u_main (
    .clock(clock), .reset_n(reset_n), .i_clr(flush), .i_load(w_main_ld),
    .i_valid(w_from_skid || w_accept), .i_wb_ctrl(w_main_ctrl_in), .i_data(w_main_data_in),
    .i_reg(w_main_reg_in), .o_valid(w_main_valid), .o_wb_ctrl(w_main_ctrl),
    .o_data(w_main_data), .o_reg(w_main_reg)
  );
  wb_entry_reg #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .WB_CTRL_W(WB_CTRL_W)) u_skid (
    .clock(clock), .reset_n(reset_n), .i_clr(flush), .i_load(w_skid_ld),
    .i_valid(w_accept), .i_wb_ctrl(in_wb_ctrl), .i_data(w_in_data),
    .i_reg(in_write_reg), .o_valid(w_skid_valid), .o_wb_ctrl(w_skid_ctrl),
    .o_data(w_skid_data), .o_reg(w_skid_reg)
  );
  assign out_valid      = w_main_valid;
  assign out_wb_ctrl    = w_main_ctrl;
  assign out_write_data = w_main_data;
  assign out_write_reg  = w_main_reg;
  assign out_reg_write  = w_main_valid && w_main_ctrl[WB_REGWRITE_BIT] && (w_main_reg != '0);
  assign fwd_valid      = out_reg_write;
  assign fwd_reg        = w_main_reg;
  assign fwd_data       = w_main_data;
endmodule

// File: tb/tb_wb_skid_reg.sv
// tb_wb_skid_reg: randomized and directed check of wb_skid_reg against a queue-based model
module tb_wb_skid_reg;
  logic        clock = 1'b0;
  logic        reset_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_reg_write, fwd_valid;
  logic [1:0]  in_wb_ctrl, out_wb_ctrl;
  logic [31:0] in_mem_data, in_alu_result, out_write_data, fwd_data;
  logic [4:0]  in_write_reg, out_write_reg, fwd_reg;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {logic [1:0] c; logic [31:0] d; logic [4:0] r;} ent_t;
  ent_t q[$];
  bit m_zero = 1'b0;
  bit started = 1'b0;
  always #5 clock = ~clock;
  wb_skid_reg dut (
    .clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_ctrl(in_wb_ctrl), .in_mem_data(in_mem_data), .in_alu_result(in_alu_result),
    .in_write_reg(in_write_reg), .out_valid(out_valid), .out_ready(out_ready),
    .out_reg_write(out_reg_write), .out_wb_ctrl(out_wb_ctrl), .out_write_data(out_write_data),
    .out_write_reg(out_write_reg), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: a FIFO of at most two entries; ready whenever fewer than two are held
  always @(posedge clock) begin
    automatic bit acc = in_valid && (q.size() < 2);
    automatic bit drn = (q.size() > 0) && out_ready;
    if (!reset_n) begin
      q.delete();
      m_zero = 1'b1;
      started = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back('{in_wb_ctrl, in_wb_ctrl[0] ? in_mem_data : in_alu_result, in_write_reg});
        m_zero = 1'b0;
      end
    end
  end
  always @(negedge clock) begin
    if (started) begin
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, q.size() < 2);
      if (q.size() > 0) begin
        chk("out_wb_ctrl", out_wb_ctrl, q[0].c);
        chk("out_write_data", out_write_data, q[0].d);
        chk("out_write_reg", out_write_reg, q[0].r);
        chk("out_reg_write", out_reg_write, q[0].c[1] && q[0].r != 0);
        chk("fwd_valid", fwd_valid, q[0].c[1] && q[0].r != 0);
        chk("fwd_reg", fwd_reg, q[0].r);
        chk("fwd_data", fwd_data, q[0].d);
      end else begin
        chk("out_reg_write_idle", out_reg_write, 0);
        chk("fwd_valid_idle", fwd_valid, 0);
        if (m_zero) begin
          chk("rst_ctrl", out_wb_ctrl, 0);
          chk("rst_data", out_write_data, 0);
          chk("rst_reg", out_write_reg, 0);
          chk("rst_fwd_data", fwd_data, 0);
          chk("rst_fwd_reg", fwd_reg, 0);
        end
      end
    end
  end
  task automatic drive(input bit v, input logic [1:0] c, input logic [31:0] m, input logic [31:0] a, input logic [4:0] r);
    in_valid = v; in_wb_ctrl = c; in_mem_data = m; in_alu_result = a; in_write_reg = r;
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  initial begin
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(0, 2'b00, 0, 0, 0);
    step; step;
    chk("lit_reset_valid", out_valid, 0);
    chk("lit_reset_ready", in_ready, 1);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'b10, 32'h5555, 32'h10 * (i + 1), 5'(i + 1));
      step;
      chk("lit_stream_data", out_write_data, 32'h10 * (i + 1));
      chk("lit_stream_rw", out_reg_write, 1);
    end
    drive(1, 2'b11, 32'hDEADBEEF, 32'h1, 5'd7);
    step;
    chk("lit_memtoreg", out_write_data, 32'hDEADBEEF);
    drive(1, 2'b10, 32'hDEADBEEF, 32'h1, 5'd7);
    step;
    chk("lit_alu_sel", out_write_data, 32'h1);
    drive(0, 2'b00, 0, 0, 0);
    step;
    out_ready = 1'b0;
    drive(1, 2'b10, 0, 32'hA, 5'd10); step;
    chk("lit_stall_a", out_write_data, 32'hA);
    drive(1, 2'b10, 0, 32'hB, 5'd11); step;
    chk("lit_stall_hold_a", out_write_data, 32'hA);
    chk("lit_stall_ready0", in_ready, 0);
    drive(1, 2'b10, 0, 32'hC, 5'd12); step;
    chk("lit_stall_still_a", out_write_data, 32'hA);
    out_ready = 1'b1;
    step;
    chk("lit_release_b", out_write_data, 32'hB);
    chk("lit_release_ready", in_ready, 1);
    step;
    chk("lit_release_c", out_write_data, 32'hC);
    drive(0, 2'b00, 0, 0, 0); step;
    chk("lit_drained", out_valid, 0);
    drive(1, 2'b10, 0, 32'h77, 5'd0); step;
    chk("lit_r0_valid", out_valid, 1);
    chk("lit_r0_rw", out_reg_write, 0);
    chk("lit_r0_fwd", fwd_valid, 0);
    drive(0, 2'b00, 0, 0, 0); step;
    out_ready = 1'b0;
    drive(1, 2'b10, 0, 32'h1, 5'd1); step;
    drive(1, 2'b10, 0, 32'h2, 5'd2); step;
    chk("lit_full_ready", in_ready, 0);
    flush = 1'b1;
    drive(1, 2'b10, 0, 32'h3, 5'd3); step;
    flush = 1'b0;
    chk("lit_flush_valid", out_valid, 0);
    chk("lit_flush_ready", in_ready, 1);
    drive(0, 2'b00, 0, 0, 0); step;
    chk("lit_flush_dropped", out_valid, 0);
    out_ready = 1'b1;
    drive(1, 2'b10, 0, 32'h44, 5'd4); step;
    reset_n = 1'b0;
    drive(1, 2'b10, 0, 32'h45, 5'd5); step;
    chk("lit_midrst_valid", out_valid, 0);
    chk("lit_midrst_data", out_write_data, 0);
    reset_n = 1'b1;
    drive(1, 2'b10, 0, 32'h46, 5'd6); step;
    chk("lit_resume_data", out_write_data, 32'h46);
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 63) != 0);
      flush = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drive($urandom_range(0, 3) != 0, 2'($urandom), $urandom, $urandom, 5'($urandom_range(0, 7)));
      step;
    end
    reset_n = 1'b1; flush = 1'b0;
    drive(0, 2'b00, 0, 0, 0);
    step; step;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
